shift_unit_mc: RTL and testbench
================================

// Module: shift_unit_mc
// PURPOSE
//  Multi-cycle, parametrised shifter/rotator for the MIPS execute stage. It
//  supersedes the 2-bit combinational shifter: any width, full shift range,
//  four ops (SLL/SRL/SRA/ROR), a shifted-out carry flag and a zero flag.
//  Moves at most STEP bit positions per cycle.
//  Handshakes valid/ready with the issue logic and with writeback.
// PARAMETERS
//  WIDTH    32                data width, >=2
//  SHAMT_W  $clog2(WIDTH)     shift-amount width
//  STEP     4                 max bit positions per cycle; power of 2, 1..WIDTH
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  flush      in   1        synchronous abort of any operation in flight
//  in_valid   in   1        operand/op presented
//  in_ready   out  1        unit can accept (state IDLE)
//  in_data    in   WIDTH    operand
//  in_shamt   in   SHAMT_W  shift amount, 0..WIDTH-1
//  in_op      in   2        00 SLL, 01 SRL, 10 SRA, 11 ROR
//  out_valid  out  1        result available (state DONE)
//  out_ready  in   1        consumer takes result
//  out_data   out  WIDTH    result
//  out_carry  out  1        last bit shifted out; ROR: result MSB; shamt=0: 0
//  out_zero   out  1        out_data == 0
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, in_ready=1, out_valid=0,
//    out_data=0, out_carry=0, out_zero=1, remaining count=0.
//  - FSM IDLE -> SHIFT -> DONE -> IDLE.
//    IDLE: in_ready=1. On in_valid&in_ready, capture data, op and shamt.
//      Go to SHIFT if shamt!=0, else DONE (data unchanged, carry=0).
//    SHIFT: each cycle k=min(remaining,STEP); apply op by k; remaining-=k.
//      carry <= last bit moved out (SLL: bit WIDTH-k; SRL/SRA: bit k-1).
//      When remaining reaches 0 in this cycle, go to DONE.
//    DONE: out_valid=1, outputs stable; on out_ready -> IDLE (same edge).
//      No acceptance in DONE: in_ready=0.
//  - Latency accept->out_valid = 1+ceil(shamt/STEP) cycles; shamt=0 -> 1.
//  - SRA fills with the captured sign bit. ROR wraps; ROR by 0 = identity.
//  - in_shamt is unsigned, with no truncation beyond SHAMT_W; all values are legal.
//  - out_zero is derived combinationally from the out_data register.
//  - flush=1 forces IDLE next edge from any state. It drops out_valid and
//    takes priority over in_valid and out_ready in the same cycle.
//    out_data/out_carry keep their last value.
//  - Inputs are ignored outside IDLE; the captured operand is immune to input changes.
//  - Async reset mid-SHIFT returns to reset values immediately; no result is emitted.
// STRUCTURE
//  - Shared package mips_pkg: SHIFT_OP_SLL/SRL/SRA/ROR 2-bit localparams and
//    the shift_op_t typedef, so the decoder and ALU use one encoding.
//  - Sub-module shift_step: combinational, WIDTH/STEP params.
//    Inputs: data, op, k (0..STEP). Outputs: shifted data and carry.
//    Instantiated once per unit.
//  - Top: FSM, operand/remaining/carry registers, handshake logic.
// TESTING
//  1 Reset: rst_n=0 -> in_ready=1, out_valid=0, out_data=0, out_zero=1.
//  2 SLL 0x0000_0001 by 31, STEP=4 -> out_valid after 9 cycles,
//    out_data=0x8000_0000, carry=0.
//  3 SRA 0x8000_00F0 by 4 -> 0xF800_000F, carry=0, latency 2.
//    SRL same -> 0x0800_000F.
//  4 ROR 0x1234_5678 by 8 -> 0x7812_3456, carry=0.
//    Shamt=0 -> 0x1234_5678, carry=0, latency 1.
//  5 Backpressure: out_ready=0 for 5 cycles -> out_valid/out_data held,
//    in_ready=0; a new in_valid is not accepted until the out_ready handshake.
//  6 flush on the 2nd SHIFT cycle of SLL by 20 -> IDLE next cycle,
//    no out_valid; the following op completes correctly.
//    Also repeat 2 with STEP=1 (32-cycle path) and STEP=32 (1 shift cycle).

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage encodings: shift op codes and the shift unit FSM states.
package mips_pkg;

  typedef logic [1:0] shift_op_t;

  localparam shift_op_t SHIFT_OP_SLL = 2'b00;
  localparam shift_op_t SHIFT_OP_SRL = 2'b01;
  localparam shift_op_t SHIFT_OP_SRA = 2'b10;
  localparam shift_op_t SHIFT_OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } shift_state_e;

endpackage

// File: rtl/shift_unit_mc_if.sv
// Issue-side and writeback-side handshake bundle of the multi-cycle shifter.
interface shift_unit_mc_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) ();
  import mips_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  shift_op_t          in_op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_carry;
  logic               out_zero;

  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero
  );

endinterface

// File: rtl/shift_step.sv
// One combinational shift/rotate pass by k (0..STEP) positions, with the last bit moved out.
module shift_step
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4
) (
  input  logic [WIDTH-1:0]           data_i,
  input  shift_op_t                  op_i,
  input  logic [$clog2(STEP+1)-1:0]  k_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       carry_o
);

  // One guard bit on the exit side of each shift catches the bit moved out last.
  logic [WIDTH:0]        sll_w;
  logic [WIDTH:0]        srl_w;
  logic signed [WIDTH:0] sra_w;
  logic [WIDTH-1:0]      ror_w;

  always_comb begin
    sll_w   = {1'b0, data_i} << k_i;
    srl_w   = {data_i, 1'b0} >> k_i;
    sra_w   = $signed({data_i, 1'b0}) >>> k_i;
    ror_w   = WIDTH'({data_i, data_i} >> k_i);
    data_o  = data_i;
    carry_o = 1'b0;
    case (op_i)
      SHIFT_OP_SLL: begin data_o = sll_w[WIDTH-1:0]; carry_o = sll_w[WIDTH]; end
      SHIFT_OP_SRL: begin data_o = srl_w[WIDTH:1];   carry_o = srl_w[0];     end
      SHIFT_OP_SRA: begin data_o = sra_w[WIDTH:1];   carry_o = sra_w[0];     end
      default:      begin data_o = ror_w;            carry_o = ror_w[WIDTH-1]; end
    endcase
    if (k_i == '0) carry_o = 1'b0;
  end

endmodule

// File: rtl/shift_unit_mc.sv
// Multi-cycle shifter/rotator: IDLE accepts an op, SHIFT moves up to STEP bits per cycle,
// DONE holds the result until writeback takes it.
module shift_unit_mc
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH),
  parameter int unsigned STEP    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  shift_unit_mc_if.slave  bus
);

  localparam int unsigned KW = $clog2(STEP + 1);

  shift_state_e       state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  shift_op_t          op_q, op_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [KW-1:0]      k_c;
  logic [WIDTH-1:0]   step_data_c;
  logic               step_carry_c;

  // Per-cycle step size: min(remaining, STEP).
  always_comb begin
    if (32'(rem_q) >= 32'(STEP)) k_c = KW'(STEP);
    else                         k_c = KW'(rem_q);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data_i  (data_q),
    .op_i    (op_q),
    .k_i     (k_c),
    .data_o  (step_data_c),
    .carry_o (step_carry_c)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    rem_d   = rem_q;
    res_d   = res_q;
    carry_d = carry_q;
    if (flush) begin
      state_d = ST_IDLE;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            data_d = bus.in_data;
            op_d   = bus.in_op;
            rem_d  = bus.in_shamt;
            if (bus.in_shamt == '0) begin
              state_d = ST_DONE;
              res_d   = bus.in_data;
              carry_d = 1'b0;
            end else begin
              state_d = ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          data_d = step_data_c;
          rem_d  = rem_q - SHAMT_W'(k_c);
          if (rem_d == '0) begin
            state_d = ST_DONE;
            res_d   = step_data_c;
            carry_d = step_carry_c;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      op_q        <= SHIFT_OP_SLL;
      rem_q       <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      op_q        <= op_d;
      rem_q       <= rem_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = res_q;
  assign bus.out_carry = carry_q;
  assign bus.out_zero  = (res_q == '0);

endmodule

// File: tb/tb_shift_unit_mc.sv
// Directed bench for shift_unit_mc: scoreboarded results on a STEP=4 unit, plus
// STEP=1 and STEP=32 units running the same long shift side by side.
module tb_shift_unit_mc;
  import mips_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned SW = 5;

  logic clk       = 1'b0;
  logic rst_n     = 1'b1;
  logic flush     = 1'b0;
  logic flush_alt = 1'b0;

  always #5 clk = ~clk;

  shift_unit_mc_if #(.WIDTH(W), .SHAMT_W(SW)) b4  ();
  shift_unit_mc_if #(.WIDTH(W), .SHAMT_W(SW)) b1  ();
  shift_unit_mc_if #(.WIDTH(W), .SHAMT_W(SW)) b32 ();

  shift_unit_mc #(.WIDTH(W), .SHAMT_W(SW), .STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b4.slave));
  shift_unit_mc #(.WIDTH(W), .SHAMT_W(SW), .STEP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush_alt), .bus(b1.slave));
  shift_unit_mc #(.WIDTH(W), .SHAMT_W(SW), .STEP(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush_alt), .bus(b32.slave));

  typedef struct {
    logic [31:0] data;
    logic        carry;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bit-at-a-time reference: returns {carry, result}.
  function automatic logic [32:0] model(input logic [31:0] d, input logic [4:0] sh,
                                        input shift_op_t op);
    logic [31:0] r;
    logic        c;
    r = d;
    c = 1'b0;
    for (int i = 0; i < int'(sh); i++) begin
      case (op)
        SHIFT_OP_SLL: begin c = r[31]; r = {r[30:0], 1'b0}; end
        SHIFT_OP_SRL: begin c = r[0];  r = {1'b0, r[31:1]}; end
        SHIFT_OP_SRA: begin c = r[0];  r = {r[31], r[31:1]}; end
        default:      begin c = r[0];  r = {r[0], r[31:1]}; end
      endcase
    end
    return {c, r};
  endfunction

  task automatic issue(input logic [31:0] d, input logic [4:0] sh, input shift_op_t op);
    logic [32:0] m;
    exp_t        e;
    int          n;
    n = 0;
    while (b4.in_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) check("in_ready_timeout", 32'd0, 32'd1);
    b4.in_valid = 1'b1;
    b4.in_data  = d;
    b4.in_shamt = sh;
    b4.in_op    = op;
    m       = model(d, sh, op);
    e.data  = m[31:0];
    e.carry = m[32];
    e.lat   = 1 + (int'(sh) + 3) / 4;
    sbq.push_back(e);
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int lat;
    lat = 1;
    while (b4.out_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    if (sbq.size() == 0) check({tag, "_sb_empty"}, 32'd0, 32'd1);
    else                 check({tag, "_lat"}, 32'(lat), 32'(sbq[0].lat));
  endtask

  task automatic consume(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sbq.pop_front();
    check({tag, "_valid"}, 32'(b4.out_valid), 32'd1);
    check({tag, "_data"},  b4.out_data, e.data);
    check({tag, "_carry"}, 32'(b4.out_carry), 32'(e.carry));
    check({tag, "_zero"},  32'(b4.out_zero), 32'(e.data == 32'd0));
    b4.out_ready = 1'b1;
    @(posedge clk); #1;
    b4.out_ready = 1'b0;
    check({tag, "_rdy_after"}, 32'(b4.in_ready), 32'd1);
    check({tag, "_vld_after"}, 32'(b4.out_valid), 32'd0);
  endtask

  task automatic alt_set(input logic v, input logic [31:0] d, input logic [4:0] sh,
                         input shift_op_t op, input logic rdy);
    b1.in_valid  = v;   b32.in_valid  = v;
    b1.in_data   = d;   b32.in_data   = d;
    b1.in_shamt  = sh;  b32.in_shamt  = sh;
    b1.in_op     = op;  b32.in_op     = op;
    b1.out_ready = rdy; b32.out_ready = rdy;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"},  32'(b4.in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(b4.out_valid), 32'd0);
    check({tag, "_out_data"},  b4.out_data,       32'd0);
    check({tag, "_out_carry"}, 32'(b4.out_carry), 32'd0);
    check({tag, "_out_zero"},  32'(b4.out_zero),  32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] last_data;
    logic [32:0] m;
    int          seen_valid;
    int          lat1, lat32;

    b4.in_valid = 1'b0; b4.in_data = '0; b4.in_shamt = '0; b4.in_op = SHIFT_OP_SLL;
    b4.out_ready = 1'b0;
    alt_set(1'b0, 32'd0, 5'd0, SHIFT_OP_SLL, 1'b0);

    // Reset values
    #2 rst_n = 1'b0;
    #1 check_reset("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(32'h0000_0001, 5'd31, SHIFT_OP_SLL); wait_out("sll31"); consume("sll31");
    issue(32'h8000_00F0, 5'd4,  SHIFT_OP_SRA); wait_out("sra4");  consume("sra4");
    issue(32'h8000_00F0, 5'd4,  SHIFT_OP_SRL); wait_out("srl4");  consume("srl4");
    issue(32'h1234_5678, 5'd8,  SHIFT_OP_ROR); wait_out("ror8");  consume("ror8");
    issue(32'h1234_5678, 5'd0,  SHIFT_OP_ROR); wait_out("ror0");  consume("ror0");
    issue(32'h0000_000F, 5'd4,  SHIFT_OP_SRL); wait_out("srl_z"); consume("srl_z");
    issue(32'h8000_0001, 5'd31, SHIFT_OP_SRA); wait_out("sra31"); consume("sra31");

    // Backpressure: result held and a competing request is not taken
    issue(32'h0000_00FF, 5'd12, SHIFT_OP_ROR); wait_out("bp");
    for (int i = 0; i < 5; i++) begin
      b4.in_valid = 1'b1; b4.in_data = 32'hDEAD_BEEF; b4.in_shamt = 5'd4; b4.in_op = SHIFT_OP_SLL;
      check("bp_valid_hold", 32'(b4.out_valid), 32'd1);
      check("bp_data_hold",  b4.out_data, sbq[0].data);
      check("bp_in_ready",   32'(b4.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    consume("bp");
    issue(32'hDEAD_BEEF, 5'd4, SHIFT_OP_SLL); wait_out("post_bp");
    last_data = sbq[0].data;
    consume("post_bp");

    // Flush on the second SHIFT cycle
    b4.in_valid = 1'b1; b4.in_data = 32'h0000_0003; b4.in_shamt = 5'd20; b4.in_op = SHIFT_OP_SLL;
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready",  32'(b4.in_ready),  32'd1);
    check("flush_out_valid", 32'(b4.out_valid), 32'd0);
    check("flush_data_kept", b4.out_data, last_data);
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      if (b4.out_valid !== 1'b0) seen_valid++;
      @(posedge clk); #1;
    end
    check("flush_no_valid", 32'(seen_valid), 32'd0);
    issue(32'h0000_0003, 5'd20, SHIFT_OP_SLL); wait_out("post_flush"); consume("post_flush");

    // Async reset in the middle of SHIFT
    b4.in_valid = 1'b1; b4.in_data = 32'hFFFF_0000; b4.in_shamt = 5'd24; b4.in_op = SHIFT_OP_SRL;
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 check_reset("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 10; i++) begin
      if (b4.out_valid !== 1'b0) seen_valid++;
      @(posedge clk); #1;
    end
    check("midreset_no_valid", 32'(seen_valid), 32'd0);

    // Same long shift on STEP=1 and STEP=32 units
    check("alt1_ready",  32'(b1.in_ready),  32'd1);
    check("alt32_ready", 32'(b32.in_ready), 32'd1);
    m = model(32'h0000_0001, 5'd31, SHIFT_OP_SLL);
    alt_set(1'b1, 32'h0000_0001, 5'd31, SHIFT_OP_SLL, 1'b0);
    @(posedge clk); #1;
    alt_set(1'b0, 32'h0000_0001, 5'd31, SHIFT_OP_SLL, 1'b0);
    lat1  = 0;
    lat32 = 0;
    for (int c = 1; c <= 40; c++) begin
      if (lat1  == 0 && b1.out_valid  === 1'b1) lat1  = c;
      if (lat32 == 0 && b32.out_valid === 1'b1) lat32 = c;
      @(posedge clk); #1;
    end
    check("step1_lat",    32'(lat1),  32'd32);
    check("step32_lat",   32'(lat32), 32'd2);
    check("step1_data",   b1.out_data,  m[31:0]);
    check("step32_data",  b32.out_data, m[31:0]);
    check("step1_carry",  32'(b1.out_carry),  32'(m[32]));
    check("step32_carry", 32'(b32.out_carry), 32'(m[32]));
    alt_set(1'b0, 32'd0, 5'd0, SHIFT_OP_SLL, 1'b1);
    @(posedge clk); #1;
    alt_set(1'b0, 32'd0, 5'd0, SHIFT_OP_SLL, 1'b0);
    check("step1_done",  32'(b1.out_valid),  32'd0);
    check("step32_done", 32'(b32.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
